// File: rtl/game_sequencer_pkg.sv
// Shared types and constants for the dino runner game sequencer.
// State encoding matches the VGA controller's view of the game.
package game_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_OVER = 2'd2
    } state_e;

    localparam logic [31:0] CACTI_START = 32'd550;
    localparam logic [31:0] CACTI_MIN_X = 32'd10;
    localparam logic [31:0] GROUND_Y    = 32'd275;

    localparam logic signed [7:0] JUMP_V0 = 8'sd14;
    localparam logic signed [7:0] GRAVITY = 8'sd1;

    // Top edge of the dino on the first frame of a jump.
    localparam logic [31:0] JUMP_Y = GROUND_Y - {24'd0, JUMP_V0};

    localparam logic [2:0] SPEED_INIT = 3'd1;
    localparam logic [2:0] SPEED_MAX  = 3'd6;

    localparam int        SCORE_W   = 16;
    localparam logic [6:0] STEP_LAST = 7'd99;

    function automatic logic [2:0] speed_up(input logic [2:0] s);
        return (s < SPEED_MAX) ? s + 3'd1 : SPEED_MAX;
    endfunction

endpackage

// File: rtl/game_sequencer_jump_physics.sv
// Dino vertical motion: position/velocity registers advanced once per step.
// Ports: clk, reset, step, jump, fast, reinit in; dino_y out.
module game_sequencer_jump_physics
    import game_sequencer_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        step,
    input  logic        jump,
    input  logic        fast,
    input  logic        reinit,
    output logic [31:0] dino_y
);

    logic [31:0]        dino_y_q, dino_y_d;
    logic signed [7:0]  vel_q, vel_d;
    logic signed [7:0]  grav;
    logic signed [7:0]  vel_n;
    logic signed [32:0] y_n;
    logic               grounded;

    always_comb begin
        dino_y_d = dino_y_q;
        vel_d    = vel_q;
        grounded = (dino_y_q == GROUND_Y) && (vel_q == 8'sd0);
        grav     = fast ? (GRAVITY + GRAVITY) : GRAVITY;
        // Velocity is decremented before it moves the dino,
        // giving apex 170 on tick 14 and touchdown on tick 29.
        vel_n    = vel_q - grav;
        // 33-bit signed so a high apex cannot wrap past row 0.
        y_n      = $signed({1'b0, dino_y_q}) - 33'(vel_n);
        if (reinit) begin
            dino_y_d = GROUND_Y;
            vel_d    = 8'sd0;
        end else if (step) begin
            if (grounded) begin
                if (jump) begin
                    dino_y_d = JUMP_Y;
                    vel_d    = JUMP_V0;
                end
            end else if (y_n >= $signed({1'b0, GROUND_Y})) begin
                dino_y_d = GROUND_Y;
                vel_d    = 8'sd0;
            end else begin
                dino_y_d = y_n[31:0];
                vel_d    = vel_n;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dino_y_q <= GROUND_Y;
            vel_q    <= 8'sd0;
        end else begin
            dino_y_q <= dino_y_d;
            vel_q    <= vel_d;
        end
    end

    assign dino_y = dino_y_q;

endmodule

// File: rtl/game_sequencer.sv
// Game FSM (IDLE/RUN/OVER), cactus scroll, score and speed counters.
// Ports: clk, reset, frame_tick, up, down, collision in;
//        game_on, game_over, dino_y, cacti_x, score, speed out.
module game_sequencer
    import game_sequencer_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic               up,
    input  logic               down,
    input  logic               collision,
    output logic               game_on,
    output logic               game_over,
    output logic [31:0]        dino_y,
    output logic [31:0]        cacti_x,
    output logic [SCORE_W-1:0] score,
    output logic [2:0]         speed
);

    state_e             state_q, state_d;
    logic               up_q;
    logic [31:0]        cacti_x_q, cacti_x_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [2:0]         speed_q, speed_d;
    logic [6:0]         step_cnt_q, step_cnt_d;

    logic up_rise;
    logic step;
    logic reinit;

    assign up_rise = up & ~up_q;
    // Collision wins over a same-cycle frame tick.
    assign step    = frame_tick & (state_q == ST_RUN) & ~collision;
    assign reinit  = (state_q == ST_IDLE)
                   | ((state_q == ST_OVER) & up_rise);

    always_comb begin
        state_d    = state_q;
        cacti_x_d  = cacti_x_q;
        score_d    = score_q;
        speed_d    = speed_q;
        step_cnt_d = step_cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                cacti_x_d  = CACTI_START;
                score_d    = '0;
                speed_d    = SPEED_INIT;
                step_cnt_d = 7'd0;
                if (up_rise) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (collision) begin
                    state_d = ST_OVER;
                end else if (frame_tick) begin
                    if (cacti_x_q < CACTI_MIN_X + {29'd0, speed_q})
                        cacti_x_d = CACTI_START;
                    else
                        cacti_x_d = cacti_x_q - {29'd0, speed_q};
                    if (score_q != '1) score_d = score_q + 1'b1;
                    if (step_cnt_q == STEP_LAST) begin
                        step_cnt_d = 7'd0;
                        speed_d    = speed_up(speed_q);
                    end else begin
                        step_cnt_d = step_cnt_q + 7'd1;
                    end
                end
            end
            ST_OVER: begin
                if (up_rise) begin
                    state_d    = ST_IDLE;
                    cacti_x_d  = CACTI_START;
                    score_d    = '0;
                    speed_d    = SPEED_INIT;
                    step_cnt_d = 7'd0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            up_q       <= 1'b0;
            cacti_x_q  <= CACTI_START;
            score_q    <= '0;
            speed_q    <= SPEED_INIT;
            step_cnt_q <= 7'd0;
        end else begin
            state_q    <= state_d;
            up_q       <= up;
            cacti_x_q  <= cacti_x_d;
            score_q    <= score_d;
            speed_q    <= speed_d;
            step_cnt_q <= step_cnt_d;
        end
    end

    game_sequencer_jump_physics u_jump (
        .clk    (clk),
        .reset  (reset),
        .step   (step),
        .jump   (up),
        .fast   (down),
        .reinit (reinit),
        .dino_y (dino_y)
    );

    assign game_on   = (state_q != ST_IDLE);
    assign game_over = (state_q == ST_OVER);
    assign cacti_x   = cacti_x_q;
    assign score     = score_q;
    assign speed     = speed_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer.
// Steps are driven and sampled on the falling edge.
module tb_game_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        frame_tick;
    logic        up;
    logic        down;
    logic        collision;
    logic        game_on;
    logic        game_over;
    logic [31:0] dino_y;
    logic [31:0] cacti_x;
    logic [15:0] score;
    logic [2:0]  speed;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    game_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .up         (up),
        .down       (down),
        .collision  (collision),
        .game_on    (game_on),
        .game_over  (game_over),
        .dino_y     (dino_y),
        .cacti_x    (cacti_x),
        .score      (score),
        .speed      (speed)
    );

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1;
            @(negedge clk);
            frame_tick = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic chk_world(input string tag,
                             input logic [31:0] cx,
                             input logic [31:0] sc,
                             input logic [31:0] sp,
                             input logic [31:0] dy);
        chk({tag, "_cacti"}, cacti_x, cx);
        chk({tag, "_score"}, {16'd0, score}, sc);
        chk({tag, "_speed"}, {29'd0, speed}, sp);
        chk({tag, "_dino"}, dino_y, dy);
    endtask

    initial begin
        reset      = 1'b1;
        frame_tick = 1'b0;
        up         = 1'b0;
        down       = 1'b0;
        collision  = 1'b0;
        cyc(3);
        reset = 1'b0;
        cyc(1);
        chk("rst_on", {31'd0, game_on}, 32'd0);
        chk("rst_over", {31'd0, game_over}, 32'd0);
        chk_world("rst", 550, 0, 1, 275);

        // Frame ticks while idle do nothing.
        tick(3);
        chk_world("idle_tick", 550, 0, 1, 275);

        // Start.
        up = 1'b1;
        cyc(1);
        up = 1'b0;
        chk("start_on", {31'd0, game_on}, 32'd1);
        chk("start_over", {31'd0, game_over}, 32'd0);
        chk_world("start", 550, 0, 1, 275);

        // Scroll and speed ramp.
        tick(1);
        chk_world("t1", 549, 1, 1, 275);
        tick(99);
        chk_world("t100", 450, 100, 2, 275);
        tick(440);
        chk_world("t540", 436, 540, 6, 275);

        // Normal jump.
        up = 1'b1;
        tick(1);
        up = 1'b0;
        chk("j1", dino_y, 261);
        tick(1);
        chk("j2", dino_y, 248);
        tick(12);
        chk("j14_apex", dino_y, 170);
        up = 1'b1;
        tick(1);
        up = 1'b0;
        chk("j15_midair_up", dino_y, 170);
        tick(13);
        chk("j28", dino_y, 261);
        tick(1);
        chk("j29_land", dino_y, 275);
        tick(1);
        chk("j30_stay", dino_y, 275);

        // Fast fall jump.
        up   = 1'b1;
        down = 1'b1;
        tick(1);
        up = 1'b0;
        chk("f1", dino_y, 261);
        tick(1);
        chk("f2", dino_y, 249);
        tick(5);
        chk("f7_apex", dino_y, 219);
        tick(7);
        chk("f14", dino_y, 261);
        tick(1);
        chk("f15_land", dino_y, 275);
        down = 1'b0;

        // Collision with same-cycle tick.
        collision  = 1'b1;
        frame_tick = 1'b1;
        cyc(1);
        collision  = 1'b0;
        frame_tick = 1'b0;
        chk("hit_over", {31'd0, game_over}, 32'd1);
        chk("hit_on", {31'd0, game_on}, 32'd1);
        chk_world("hit", 166, 585, 6, 275);
        tick(5);
        collision = 1'b1;
        down      = 1'b1;
        tick(2);
        collision = 1'b0;
        down      = 1'b0;
        chk("frz_over", {31'd0, game_over}, 32'd1);
        chk_world("frz", 166, 585, 6, 275);

        // Restart path: OVER -> IDLE -> RUN.
        up = 1'b1;
        cyc(1);
        up = 1'b0;
        chk("rs_on", {31'd0, game_on}, 32'd0);
        chk("rs_over", {31'd0, game_over}, 32'd0);
        chk_world("rs", 550, 0, 1, 275);
        cyc(1);
        up = 1'b1;
        cyc(1);
        chk("rs2_on", {31'd0, game_on}, 32'd1);
        tick(1);
        up = 1'b0;
        chk("rs2_j1", dino_y, 261);
        tick(1);
        chk_world("rs2_t2", 548, 2, 1, 248);

        // Reset mid-jump.
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        chk("mrst_on", {31'd0, game_on}, 32'd0);
        chk("mrst_over", {31'd0, game_over}, 32'd0);
        chk_world("mrst", 550, 0, 1, 275);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
